// File: rtl/clk_buffer_if.sv
`timescale 1ns/1ps
// Branch-clock control/status bundle: enable and divide ratio in; branch clock, on flag and edge count out.
// Latency: wiring only, no storage.
// Backpressure: none; the driver side owns en/div, the buffer side owns bclk/bclk_on/edge_cnt.
interface clk_buffer_if #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) ();
    logic             en;
    logic [DIV_W-1:0] div;
    logic             bclk;
    logic             bclk_on;
    logic [CNT_W-1:0] edge_cnt;

    modport master (output en, output div, input bclk, input bclk_on, input edge_cnt);
    modport slave  (input en, input div, output bclk, output bclk_on, output edge_cnt);
endinterface

// File: rtl/clk_buffer.sv
`timescale 1ns/1ps
// Glitch-free gated and integer-divided branch clock buffer with a bclk rising-edge counter.
// Latency: pass-through is combinational (zero delay); divide mode is a register on the mclk rise.
// Backpressure: none; en takes effect at the next mclk rise, div only at a divided-period boundary.
module clk_buffer #(
    parameter int   DIV_W  = 8,
    parameter int   CNT_W  = 16,
    parameter logic EN_RST = 1'b1
) (
    input  logic        mclk,
    input  logic        rst,
    clk_buffer_if.slave bus
);
    // ST_PASS: bclk follows mclk through the enable gate.
    // ST_HALT: divide mode selected but no period running, bclk held low.
    // ST_RUN : inside a divided period, bclk driven from dclk.
    typedef enum logic [1:0] {
        ST_PASS = 2'd0,
        ST_HALT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t           state;
    logic             en_q;
    logic             armed;
    logic             on_q;
    logic             gate;
    logic             dclk;
    logic [DIV_W-1:0] ph;
    logic [DIV_W-1:0] cur_n;
    logic [DIV_W-1:0] ph_inc;
    logic [DIV_W:0]   hi_len;
    logic [CNT_W-1:0] cnt;
    logic             at_boundary;
    logic             next_high;
    logic             want_div;

    // Capture the enable while mclk is low so the gate never changes during a high phase.
    // armed holds the gate shut until the first falling edge after reset release.
    always_ff @(negedge mclk or posedge rst) begin
        if (rst) begin
            en_q  <= EN_RST;
            armed <= 1'b0;
            on_q  <= 1'b0;
        end else begin
            en_q  <= bus.en;
            armed <= 1'b1;
            on_q  <= bus.en;
        end
    end

    assign gate = en_q & armed;

    // Period bookkeeping: high length is ceil(N/2), boundary is the last mclk period of a run.
    always_comb begin
        hi_len      = ({1'b0, cur_n} + (DIV_W + 1)'(1)) >> 1;
        ph_inc      = ph + DIV_W'(1);
        next_high   = ({1'b0, ph_inc} < hi_len);
        at_boundary = (state != ST_RUN) || (ph == (cur_n - DIV_W'(1)));
        want_div    = (bus.div > DIV_W'(1));
    end

    // Mode/period state machine; div and the pass/divide choice are only taken at a boundary,
    // where bclk is low, so neither a ratio change nor a mode switch can chop a pulse.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state <= ST_PASS;
            dclk  <= 1'b0;
            ph    <= '0;
            cur_n <= '0;
            cnt   <= '0;
        end else if (at_boundary) begin
            ph <= '0;
            // bclk rises at every boundary where the gate is open, in either mode.
            if (gate) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (!want_div) begin
                state <= ST_PASS;
                dclk  <= 1'b0;
            end else begin
                cur_n <= bus.div;
                state <= gate ? ST_RUN : ST_HALT;
                dclk  <= gate;
            end
        end else if (next_high) begin
            // Still inside the high phase: keep going even if the enable dropped.
            ph   <= ph_inc;
            dclk <= 1'b1;
        end else if (!gate) begin
            // Disabled and the high phase is over: abandon the period, stay low.
            state <= ST_HALT;
            dclk  <= 1'b0;
        end else begin
            ph   <= ph_inc;
            dclk <= 1'b0;
        end
    end

    assign bus.bclk     = (state == ST_PASS) ? (mclk & gate) : dclk;
    assign bus.bclk_on  = on_q;
    assign bus.edge_cnt = cnt;
endmodule

// File: tb/tb_clk_buffer.sv
`timescale 1ns/1ps
// Bench for clk_buffer: directed timing measurements plus randomized en/div against a level-queue model.
// Latency: model predicts bclk level per mclk half-period, edge_cnt and bclk_on each cycle.
// Backpressure: not applicable; every edge wait is bounded by a timeout that counts as a failed check.
module tb_clk_buffer;
    logic mclk;
    logic rst;
    logic rst2;

    clk_buffer_if #(.DIV_W(8), .CNT_W(16)) bus ();
    clk_buffer_if #(.DIV_W(8), .CNT_W(4))  bus2 ();

    clk_buffer #(.DIV_W(8), .CNT_W(16), .EN_RST(1'b1)) dut (
        .mclk (mclk),
        .rst  (rst),
        .bus  (bus)
    );

    clk_buffer #(.DIV_W(8), .CNT_W(4), .EN_RST(1'b1)) dut_wrap (
        .mclk (mclk),
        .rst  (rst2),
        .bus  (bus2)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    bit          live   = 1'b0;
    realtime     t_m    = 0.0;
    realtime     t_mp   = 0.0;
    realtime     t_rise = 0.0;
    int          q_lvl[$];
    int          lvl_m  = 0;
    bit          gate_m = 1'b0;
    logic [15:0] cnt_m  = '0;
    int          div_n;
    bit          edge_seen;
    int          edge_sel;

    initial begin
        mclk = 1'b0;
        forever #10 mclk = ~mclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Timestamps of the two latest mclk rises.
    always @(posedge mclk) begin
        t_mp = t_m;
        t_m  = $realtime;
    end

    // Reference model: a queue of planned per-cycle levels (2 = follow mclk, 1 = high, 0 = low).
    always @(posedge rst) begin
        q_lvl.delete();
        lvl_m  = 0;
        gate_m = 1'b0;
        cnt_m  = '0;
    end

    always @(negedge mclk) begin
        if (!rst) gate_m = bus.en;
    end

    always @(posedge mclk) begin
        if (!rst) begin
            if (q_lvl.size() == 0 && gate_m) begin
                div_n = int'(bus.div);
                cnt_m = cnt_m + 16'd1;
                if (div_n < 2) q_lvl.push_back(2);
                else for (int k = 0; k < div_n; k++) q_lvl.push_back((k < (div_n + 1) / 2) ? 1 : 0);
            end
            lvl_m = (q_lvl.size() != 0) ? q_lvl.pop_front() : 0;
            if (!gate_m && lvl_m == 0) q_lvl.delete();
        end
    end

    // Continuous comparison against the model, mid high phase and mid low phase.
    always begin
        @(posedge mclk);
        #5;
        if (live && !rst) begin
            check("bclk_high_half", bus.bclk, (lvl_m != 0) ? 32'd1 : 32'd0);
            check("edge_cnt", bus.edge_cnt, cnt_m);
            check("bclk_on", bus.bclk_on, gate_m);
        end
        @(negedge mclk);
        #5;
        if (live && !rst) check("bclk_low_half", bus.bclk, (lvl_m == 1) ? 32'd1 : 32'd0);
    end

    // No bclk high pulse may be shorter than one mclk high phase (reset excepted).
    always @(posedge bus.bclk) t_rise = $realtime;
    always @(negedge bus.bclk) begin
        if (live && !rst) check("min_pulse", (($realtime - t_rise) >= 10.0) ? 32'd1 : 32'd0, 32'd1);
    end

    task wait_edge(input int sel, output realtime t);
        edge_seen = 1'b0;
        edge_sel  = sel;
        fork
            begin
                case (edge_sel)
                    0:       @(posedge bus.bclk);
                    1:       @(negedge bus.bclk);
                    default: @(posedge bus2.bclk);
                endcase
                edge_seen = 1'b1;
            end
            #400;
        join_any
        disable fork;
        t = $realtime;
        check("edge_wait", edge_seen, 1'b1);
    endtask

    task release_reset(output realtime p);
        @(posedge mclk);
        #3;
        rst = 1'b1;
        @(posedge mclk);
        p = $realtime;
        #3;
        rst = 1'b0;
    endtask

    task pass_through(input logic [7:0] d);
        realtime p, t1, t2;
        bus.div = d;
        bus.en  = 1'b1;
        release_reset(p);
        wait_edge(0, t1);
        #1;
        check("pt_first_rise", int'(t1 - p), 20);
        check("pt_align1", int'(t1), int'(t_m));
        wait_edge(0, t2);
        #1;
        check("pt_align2", int'(t2), int'(t_m));
        check("pt_bclk_period", int'(t2 - t1), 20);
        check("pt_mclk_period", int'(t_m - t_mp), 20);
    endtask

    realtime ta, tf, t1, t2, t4, t5, t6, p;

    initial begin
        rst      = 1'b1;
        rst2     = 1'b1;
        bus.en   = 1'b1;
        bus.div  = 8'd1;
        bus2.en  = 1'b1;
        bus2.div = 8'd0;
        #33;
        check("rst_bclk", bus.bclk, 0);
        check("rst_cnt", bus.edge_cnt, 0);
        check("rst_on", bus.bclk_on, 0);
        check("rst_bclk_wrap", bus2.bclk, 0);
        live = 1'b1;

        pass_through(8'd1);
        pass_through(8'd0);

        // Ten pass-through edges since the last reset.
        for (int i = 0; i < 8; i++) wait_edge(0, ta);
        #1;
        check("edge_cnt_10", bus.edge_cnt, 10);

        // Enable gating around a high phase.
        @(posedge mclk);
        #3;
        bus.en = 1'b0;
        #5;
        check("gate_keep_high", bus.bclk, 1);
        @(posedge mclk);
        #5;
        check("gate_off_low", bus.bclk, 0);
        check("gate_off_on", bus.bclk_on, 0);
        @(posedge mclk);
        #3;
        bus.en = 1'b1;
        #4;
        check("gate_pending", bus.bclk, 0);
        @(posedge mclk);
        #1;
        check("gate_resume", bus.bclk, 1);
        check("gate_resume_on", bus.bclk_on, 1);

        // Divide by 4.
        @(posedge mclk);
        #3;
        bus.div = 8'd4;
        wait_edge(0, t1);
        #1;
        check("d4_align", int'(t1), int'(t_m));
        wait_edge(1, tf);
        wait_edge(0, t2);
        check("d4_high", int'(tf - t1), 40);
        check("d4_period", int'(t2 - t1), 80);

        // Divide by 3; the running divide-by-4 period completes first.
        #3;
        bus.div = 8'd3;
        wait_edge(0, t1);
        check("d4_last_period", int'(t1 - t2), 80);
        wait_edge(1, tf);
        wait_edge(0, t2);
        #1;
        check("d3_align", int'(t2), int'(t_m));
        check("d3_high", int'(tf - t1), 40);
        check("d3_period", int'(t2 - t1), 60);

        // Ratio change 4 -> 2 halfway through a high phase.
        #2;
        bus.div = 8'd4;
        wait_edge(0, t4);
        #23;
        bus.div = 8'd2;
        wait_edge(0, t5);
        check("chg_period_kept", int'(t5 - t4), 80);
        wait_edge(0, t6);
        check("chg_new_period", int'(t6 - t5), 40);

        // Asynchronous reset in the middle of a high phase.
        #5;
        check("pre_rst_high", bus.bclk, 1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_bclk", bus.bclk, 0);
        check("async_rst_cnt", bus.edge_cnt, 0);
        check("async_rst_on", bus.bclk_on, 0);
        @(posedge mclk);
        p = $realtime;
        #3;
        rst = 1'b0;
        wait_edge(0, t1);
        check("rst_resume", int'(t1 - p), 20);

        // Randomized en/div activity checked by the model.
        for (int i = 0; i < 400; i++) begin
            @(posedge mclk);
            #($urandom_range(2, 8));
            if ($urandom_range(0, 3) == 0) bus.en = ~bus.en;
            if ($urandom_range(0, 5) == 0) bus.div = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1) begin
                #10;
                if ($urandom_range(0, 3) == 0) bus.en = ~bus.en;
            end
        end

        // Four-bit counter wraps after sixteen edges.
        @(posedge mclk);
        #3;
        rst2 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            wait_edge(2, ta);
            #1;
            check("wrap_cnt", bus2.edge_cnt, i % 16);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/clk_buffer.md
Name: clk_buffer

Overview:
- Glitch-free gated clock buffer that drives branch clock bclk from master clock mclk.
- Default mode: bclk is a zero-delay, phase- and frequency-identical copy of mclk.
  - Rising edges of bclk occur at the same simulation time as those of mclk.
- Optional glitch-free gating and integer division, plus a status/edge-count interface for clock-tree monitoring.
- Sits at the root of a local clock branch, between the master clock source and downstream logic.

Parameters:
DIV_W, 8, width of the divide-ratio input.
CNT_W, 16, width of the bclk rising-edge counter.
EN_RST, 1'b1, value the internal enable takes while reset is asserted.

Ports:
mclk  input  1  master clock; all state is timed from it.
rst  input  1  reset; asynchronous, active-high.
en  input  1  clock enable request.
div  input  DIV_W  divide ratio; 0 and 1 both mean pass-through.
bclk  output  1  buffered/gated/divided clock.
bclk_on  output  1  high while bclk is being driven (enable active).
edge_cnt  output  CNT_W  count of bclk rising edges since reset; wraps.

Behaviour:
- One clock domain (mclk). Reset rst is asynchronous, active-high.
- While rst=1:
  - bclk=0, edge_cnt=0, divider state cleared.
  - Internal enable en_q=EN_RST; bclk_on=0.
- Enable gating:
  - en is captured into en_q on the falling edge of mclk (latch-style, glitch-free).
  - Changes therefore take effect at the next mclk rising edge.
  - bclk never produces a pulse shorter than one mclk high phase.
- Pass-through (div 0 or 1): bclk = mclk AND en_q, combinational, no delay.
  - With en_q=1: bclk rising edge time == mclk rising edge time; period identical.
- Divide mode (div=N>=2):
  - bclk is driven from a register clocked by mclk.
  - Period = N mclk periods, rising edges aligned to mclk rising edges.
  - Even N: high for N/2 mclk periods.
  - Odd N: high for (N+1)/2 mclk periods.
  - bclk goes high on the first mclk rising edge after en_q goes high.
- div changes:
  - Sampled only at a divided-period boundary (bclk rising point).
  - Mid-period changes never truncate the current period.
  - Switching between pass-through and divide mode occurs only while bclk is low.
- Disabling (en_q=0): bclk finishes its current high phase, then stays low. bclk_on goes low at the same mclk edge.
- bclk_on = en_q after reset is released (registered with the falling-edge capture).
- edge_cnt:
  - Increments by 1 on each mclk rising edge at which bclk rises.
  - Wraps from all-ones to 0.
- Reset mid-operation: bclk drops to 0 immediately (asynchronous); state is cleared.
- After reset release with en=1, the first bclk rising edge coincides with the first mclk rising edge following the next mclk falling edge.

Test Plan:
- Pass-through phase/frequency: mclk period 20 ns, rst pulse then 0, en=1, div=1. Measure two consecutive posedges on each clock; require t(bclk)==t(mclk) for both, and bclk period == mclk period == 20 ns. Repeat with div=0.
- Gating: toggle en 1->0->1 around mclk high phases. Require no bclk pulse shorter than 10 ns, bclk low while disabled, bclk_on tracking en_q.
- Divide by 4 then 3: with div=4, require bclk period 80 ns, high 40 ns. With div=3, require period 60 ns, high 40 ns. Rising edges align with mclk rising edges.
- Ratio change mid-period: change div 4->2 halfway through a bclk high phase. Require the current 80 ns period to complete before the 40 ns periods start.
- Async reset: assert rst while bclk is high, between mclk edges. Require bclk=0 and edge_cnt=0 immediately. After release, require edges resume per the rule above.
- Counter: run 10 pass-through cycles, require edge_cnt=10. Preload-free wrap check with CNT_W=4: 16 edges -> edge_cnt=0.
